// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 sequencer: owns state/round-key registers, steps an external round datapath once per clock.
// Latency: out_valid rises NR+1 cycles after accept; streaming throughput is one block per NR+1 cycles.
// Backpressure: in_ready low while rounds run; DONE holds the ciphertext until out_ready and may accept the next block in that cycle.
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic [127:0] in_key,
    input  logic [127:0] rnd_state_in,
    input  logic [127:0] key_next_in,
    output logic [127:0] state_q,
    output logic [127:0] key_q,
    output logic [7:0]   rcon,
    output logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fsm_t;

    localparam logic [3:0] NR_CNT = 4'(NR);

    fsm_t       fsm;
    logic [3:0] round_cnt;
    logic       accept;
    logic       final_rnd;

    assign in_ready  = (fsm == IDLE) || ((fsm == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign final_rnd = (round_cnt == NR_CNT);
    assign out_block = state_q;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // last_round and out_valid are flops so the datapath never sees an input-driven glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm        <= IDLE;
            round_cnt  <= 4'd0;
            state_q    <= '0;
            key_q      <= '0;
            rcon       <= 8'h01;
            last_round <= 1'b0;
            out_valid  <= 1'b0;
        end else if (flush) begin
            fsm        <= IDLE;
            round_cnt  <= 4'd0;
            state_q    <= '0;
            key_q      <= '0;
            rcon       <= 8'h01;
            last_round <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            case (fsm)
                IDLE, DONE: begin
                    if (accept) begin
                        state_q    <= in_block ^ in_key;
                        key_q      <= in_key;
                        round_cnt  <= 4'd1;
                        rcon       <= 8'h01;
                        fsm        <= RUN;
                        last_round <= (NR_CNT == 4'd1);
                        out_valid  <= 1'b0;
                    end else if ((fsm == DONE) && out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                RUN: begin
                    state_q <= rnd_state_in;
                    key_q   <= key_next_in;
                    if (final_rnd) begin
                        fsm        <= DONE;
                        last_round <= 1'b0;
                        out_valid  <= 1'b1;
                    end else begin
                        round_cnt  <= round_cnt + 4'd1;
                        rcon       <= xtime(rcon);
                        last_round <= ((round_cnt + 4'd1) == NR_CNT);
                    end
                end
                default: begin
                    fsm        <= IDLE;
                    last_round <= 1'b0;
                    out_valid  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: attaches a behavioural AES round datapath and checks against a whole-block AES reference.
module tb_aes_round_ctrl;
    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_block = '0;
    logic [127:0] in_key = '0;
    logic [127:0] rnd_state_in, key_next_in, state_q, key_q, out_block;
    logic [7:0]   rcon;
    logic         in_ready, last_round, out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rcon_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(NR)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_key(in_key),
        .rnd_state_in(rnd_state_in), .key_next_in(key_next_in),
        .state_q(state_q), .key_q(key_q), .rcon(rcon), .last_round(last_round),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block)
    );

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv, sq;
        inv = 8'h01; sq = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gmul(inv, sq);
            sq = gmul(sq, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] seq2bus(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = x[127-8*i -: 8];
        return r;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] t0, t1, t2, t3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[8*i +: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) b[rr + 4*c] = a[rr + 4*((c + rr) % 4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                t0 = b[4*c]; t1 = b[4*c+1]; t2 = b[4*c+2]; t3 = b[4*c+3];
                b[4*c]   = gmul(8'h02, t0) ^ gmul(8'h03, t1) ^ t2 ^ t3;
                b[4*c+1] = t0 ^ gmul(8'h02, t1) ^ gmul(8'h03, t2) ^ t3;
                b[4*c+2] = t0 ^ t1 ^ gmul(8'h02, t2) ^ gmul(8'h03, t3);
                b[4*c+3] = gmul(8'h03, t0) ^ t1 ^ t2 ^ gmul(8'h02, t3);
            end
        end
        for (int i = 0; i < 16; i++) r[8*i +: 8] = b[i] ^ k[8*i +: 8];
        return r;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [7:0] t [4];
        logic [127:0] n;
        t[0] = sbox(k[8*13 +: 8]) ^ rc;
        t[1] = sbox(k[8*14 +: 8]);
        t[2] = sbox(k[8*15 +: 8]);
        t[3] = sbox(k[8*12 +: 8]);
        for (int j = 0; j < 4; j++) n[8*j +: 8] = k[8*j +: 8] ^ t[j];
        for (int i = 4; i < 16; i++) n[8*i +: 8] = k[8*i +: 8] ^ n[8*(i-4) +: 8];
        return n;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s, k;
        logic [7:0] rc;
        s = pt ^ key; k = key; rc = 8'h01;
        for (int r = 1; r <= NR; r++) begin
            k  = key_expand(k, rc);
            s  = aes_round(s, k, r == NR);
            rc = xt(rc);
        end
        return s;
    endfunction

    always_comb begin
        key_next_in  = key_expand(key_q, rcon);
        rnd_state_in = aes_round(state_q, key_next_in, last_round);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [127:0] b, input logic [127:0] k);
        in_block = b; in_key = k; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("accept in_ready", 128'(in_ready), 128'd1);
        tick();
        out_ready = 1'b0;
    endtask

    // Returns at the first cycle with out_valid high, leaving the block in DONE.
    task automatic wait_result(input logic [127:0] exp, input string tag);
        int lr_cnt;
        bit done;
        lr_cnt = 0; done = 0;
        for (int n = 1; n <= 3*NR && !done; n++) begin
            if (out_valid) begin
                chk({tag, " latency"}, 128'(n), 128'(NR + 1));
                chk({tag, " last_round count"}, 128'(lr_cnt), 128'd1);
                chk({tag, " out_block"}, out_block, exp);
                done = 1;
            end else begin
                if (n <= NR) begin
                    chk({tag, " rcon"}, 128'(rcon), 128'(rcon_tbl[n-1]));
                    chk({tag, " last_round"}, 128'(last_round), 128'(n == NR));
                end
                chk({tag, " in_ready in RUN"}, 128'(in_ready), 128'd0);
                lr_cnt += int'(last_round);
                tick();
            end
        end
        if (!done) chk({tag, " timeout"}, 128'(out_valid), 128'd1);
    endtask

    task automatic drain(input string tag);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " drain out_valid"}, 128'(out_valid), 128'd0);
        chk({tag, " drain in_ready"}, 128'(in_ready), 128'd1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] pt, key, ct, b2, k2, e2;
        logic [127:0] sb [5];
        logic [127:0] sk [5];

        #1 rst_n = 1'b0;
        tick(); tick();
        chk("rst in_ready", 128'(in_ready), 128'd1);
        chk("rst out_valid", 128'(out_valid), 128'd0);
        chk("rst last_round", 128'(last_round), 128'd0);
        chk("rst state_q", state_q, 128'd0);
        chk("rst key_q", key_q, 128'd0);
        chk("rst rcon", 128'(rcon), 128'h01);
        #2 rst_n = 1'b1;
        tick();

        key = seq2bus(128'h2b7e151628aed2a6abf7158809cf4f3c);
        pt  = seq2bus(128'h3243f6a8885a308d313198a2e0370734);
        ct  = seq2bus(128'h3925841d02dc09fbdc118597196a0b32);
        accept(pt, key);
        in_valid = 1'b0;
        wait_result(ct, "kat");
        drain("kat");

        for (int r = 0; r < 2; r++) begin
            pt = rnd128(); key = rnd128();
            accept(pt, key);
            in_valid = 1'b0;
            wait_result(aes_ref(pt, key), "rand");
            drain("rand");
        end

        // Backpressure: ciphertext held 20 cycles while a new block is offered.
        pt = rnd128(); key = rnd128(); ct = aes_ref(pt, key);
        b2 = rnd128(); k2 = rnd128(); e2 = aes_ref(b2, k2);
        accept(pt, key);
        in_valid = 1'b0;
        wait_result(ct, "bp1");
        in_block = b2; in_key = k2; in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp hold out_valid", 128'(out_valid), 128'd1);
            chk("bp hold out_block", out_block, ct);
            chk("bp hold in_ready", 128'(in_ready), 128'd0);
        end
        accept(b2, k2);
        in_valid = 1'b0;
        chk("bp reload out_valid", 128'(out_valid), 128'd0);
        chk("bp reload state_q", state_q, b2 ^ k2);
        chk("bp reload key_q", key_q, k2);
        wait_result(e2, "bp2");
        drain("bp2");

        // Stream of 4 with in_valid held high throughout.
        for (int i = 0; i < 5; i++) begin
            sb[i] = rnd128(); sk[i] = rnd128();
        end
        accept(sb[0], sk[0]);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                in_block = sb[i+1]; in_key = sk[i+1];
            end else begin
                in_block = sb[4]; in_key = sk[4];
            end
            wait_result(aes_ref(sb[i], sk[i]), "stream");
            if (i < 3) accept(sb[i+1], sk[i+1]);
        end
        drain("stream");

        // Flush in round 5.
        pt = rnd128(); key = rnd128();
        accept(pt, key);
        in_valid = 1'b0;
        repeat (4) tick();
        chk("flush round5 rcon", 128'(rcon), 128'h10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush in_ready", 128'(in_ready), 128'd1);
        chk("flush out_valid", 128'(out_valid), 128'd0);
        chk("flush state_q", state_q, 128'd0);
        chk("flush key_q", key_q, 128'd0);
        chk("flush last_round", 128'(last_round), 128'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("flush idle out_valid", 128'(out_valid), 128'd0);
        end
        pt = rnd128(); key = rnd128();
        accept(pt, key);
        in_valid = 1'b0;
        wait_result(aes_ref(pt, key), "post_flush");
        drain("post_flush");

        // Asynchronous reset between edges in round 7.
        pt = rnd128(); key = rnd128();
        accept(pt, key);
        in_valid = 1'b0;
        repeat (6) tick();
        chk("rst7 rcon", 128'(rcon), 128'h40);
        #2 rst_n = 1'b0;
        #1;
        chk("arst in_ready", 128'(in_ready), 128'd1);
        chk("arst out_valid", 128'(out_valid), 128'd0);
        chk("arst state_q", state_q, 128'd0);
        chk("arst key_q", key_q, 128'd0);
        chk("arst rcon", 128'(rcon), 128'h01);
        chk("arst last_round", 128'(last_round), 128'd0);
        tick(); tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("post arst out_valid", 128'(out_valid), 128'd0);
        end
        pt = rnd128(); key = rnd128();
        accept(pt, key);
        in_valid = 1'b0;
        wait_result(aes_ref(pt, key), "post_rst");
        drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES-128 encryption sequencer. It owns the 128-bit state register and the round-key register, runs one round per clock through the external combinational round datapath (sub_bytes, shift_rows, mix_columns, add_round_key, key expansion), and generates the round constant and last-round flag. It sits between the block-level valid/ready input and output streams and the round datapath.

Parameters:
NR, 10, rounds per block; legal range 1..10. 10 is the only value used for AES-128.

Ports:
clk  input  1  clock
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
flush  input  1  synchronous abort; returns the block to IDLE
in_valid  input  1  plaintext/key offered
in_ready  output  1  controller can accept
in_block  input  128  plaintext; byte i of the FIPS-197 byte sequence at bits [8i+7:8i]
in_key  input  128  cipher key; same byte order as in_block
rnd_state_in  input  128  datapath result of the current round, computed from state_q and key_next_in
key_next_in  input  128  datapath next round key, computed from key_q and rcon
state_q  output  128  current state to the datapath
key_q  output  128  current round key to the datapath
rcon  output  8  round constant for the current round
last_round  output  1  high in round NR; the datapath bypasses mix_columns
out_valid  output  1  ciphertext available
out_ready  input  1  downstream accepts
out_block  output  128  ciphertext; equals state_q while out_valid is high

Behaviour:
- Reset values:
  - FSM = IDLE, round_cnt = 0.
  - state_q = 0, key_q = 0, rcon = 8'h01.
  - in_ready = 1, out_valid = 0, last_round = 0.
- FSM states: IDLE, RUN, DONE.
- in_ready = (fsm==IDLE) | (fsm==DONE & out_ready). Combinational; never high in RUN.
- Accept (in_valid & in_ready):
  - state_q <= in_block ^ in_key (initial AddRoundKey).
  - key_q <= in_key, round_cnt <= 1, rcon <= 8'h01, fsm <= RUN.
- RUN, each cycle:
  - state_q <= rnd_state_in, key_q <= key_next_in.
  - round_cnt increments; rcon <= xtime(rcon), where xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - Sequence 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
- last_round = (fsm==RUN) & (round_cnt==NR). It is a registered decode; no glitch path from inputs.
- When round_cnt==NR in RUN, fsm <= DONE on the next edge. out_valid = (fsm==DONE).
- Latency:
  - Accept at edge T gives out_valid high in the cycle after edge T+NR (11 cycles for NR=10).
  - Throughput is one block per NR+1 cycles with back-to-back streams.
- DONE:
  - state_q and key_q are held stable until out_valid & out_ready.
  - On handshake without a new accept, fsm <= IDLE.
  - On handshake with in_valid in the same cycle, the new block loads directly into RUN with no bubble.
- in_valid while in RUN is ignored: in_ready is 0, no data is captured, and the input is not required to be held by any rule except the standard valid/ready hold.
- flush has priority over everything except reset:
  - fsm <= IDLE, round_cnt <= 0, out_valid drops next cycle.
  - state_q and key_q are cleared to 0 so no key material is retained.
- rst_n asserted mid-operation: all registers go immediately to reset values and the in-flight block is lost.
- rnd_state_in and key_next_in are sampled only in RUN; their values are don't-care elsewhere.
- round_cnt is 4 bits; it never exceeds NR.

Test Plan:
- FIPS-197 App. B with the bench round model attached: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> out_block 3925841d02dc09fbdc118597196a0b32, out_valid rising exactly 11 cycles after accept, last_round high for exactly one cycle.
- rcon trace: monitor rcon each RUN cycle -> 01,02,04,08,10,20,40,80,1b,36; last_round coincides with 36.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_block is stable, in_ready=0, and no second accept; raise out_ready together with in_valid -> new block enters RUN in the same cycle; second ciphertext is correct after 11 more cycles.
- Stream of 4 blocks with in_valid held high and out_ready=1 -> accepts every 11 cycles and all 4 ciphertexts match the model, in order.
- flush asserted in round 5 -> next cycle fsm=IDLE, in_ready=1, state_q=0, key_q=0, no out_valid; the following block produces the correct result.
- rst_n pulsed low in round 7, asynchronously between edges -> outputs take reset values immediately, not at the next edge; no spurious out_valid after release.
